my_if_pair_packer: RTL
======================

# my_if_pair_packer

- Consumes the byte stream produced on a `my_if` valid/ready channel and buffers it in a small FIFO.
- Packs consecutive bytes into two-byte packets and drives them onto a `struct_if` (`packet_field1`, `packet_field2`, `tx_en`), held until the downstream `tx_ready`.
- A byte left unpaired is flushed with a pad byte after a programmable timeout.
- Sits directly downstream of the `my_if` byte producers and upstream of the `struct_if` transmit stage.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `TIMEOUT`, 15: idle cycles in HOLD before pad flush; 0 disables the timeout (wait forever).
- `PAD`, 8'h00: value placed in `packet_field2` on pad flush.

- `clk`  in  1  clock, all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_bus`  modport `my_if.AccessOut`:
  - `data` in [7:0];
  - `valid` in 1;
  - `ready` out 1.
- `pk_bus`  modport `struct_if.Access`:
  - `packet_field1` out [7:0];
  - `packet_field2` out [7:0];
  - `tx_en` out 1.
- `tx_ready`  in  1  downstream accepts the packet when high with `tx_en`.
- `fifo_count`  out  [$clog2(DEPTH+1)-1:0]  current FIFO occupancy.
- `pad_flush`  out  1  one-cycle pulse on the cycle the FSM enters SEND via timeout.
- `pairs_sent`  out  16  count of packets accepted downstream; wraps 16'hFFFF→0.

## Operation
Ingress:
- Transfer occurs on the edge where `in_bus.valid && in_bus.ready`; the byte is pushed to the FIFO tail.
- `in_bus.ready` is registered: it takes the value (next `fifo_count` < DEPTH).
- With a full FIFO, a pop in the same cycle does not re-enable `ready` until the following edge; no overflow is possible.

Packer FSM states:
- EMPTY:
  - Nothing held.
  - If the FIFO is non-empty: pop head into `packet_field1`, clear the timer, go to HOLD.
- HOLD:
  - If the FIFO is non-empty: pop head into `packet_field2`, go to SEND.
  - Otherwise, if TIMEOUT≠0, increment the timer. When the timer reaches TIMEOUT-1: load `packet_field2`=PAD, pulse `pad_flush`, go to SEND.
  - Timer width is $clog2(TIMEOUT+1) and saturates; it never wraps.
- SEND:
  - `tx_en`=1; both fields are stable.
  - On `tx_ready`: increment `pairs_sent`.
    - If the FIFO is non-empty, pop the head into `packet_field1` and go to HOLD (back-to-back throughput of 1 byte/cycle).
    - Otherwise go to EMPTY.
  - Without `tx_ready`, stay in SEND indefinitely.

Other rules:
- Push and pop in the same cycle: `fifo_count` unchanged, order preserved.
- `tx_en` is 0 outside SEND. Fields keep their last values outside SEND; their content is don't-care when `tx_en`=0.

## Timing
Reset state (asynchronous, immediate on `reset_n` low):
- FIFO emptied, FSM in EMPTY, timer 0.
- `in_bus.ready`=0, `tx_en`=0, `pad_flush`=0, `fifo_count`=0, `pairs_sent`=0, fields 8'h00.
- `in_bus.ready` rises at the first `clk` edge after `reset_n` deasserts.

Latency:
- Byte accepted at edge N is popped at N+1 (HOLD).
- A second byte accepted at N+1 is popped at N+2, and `tx_en` is high from N+2.

Timeout:
- With no second byte, `pad_flush` and `tx_en` rise TIMEOUT cycles after entering HOLD.

Reset mid-operation:
- All buffered and held bytes are discarded; no stale packet appears after release.

## Structure
- Shared package `my_if_pair_pkg`: state enum (EMPTY, HOLD, SEND) and the PAD default constant.
- One sub-module: `my_if_byte_fifo`, a parameterised sync FIFO with:
  - ports `clk`, `reset_n`, push, pop, wdata, rdata, count, full, empty;
  - first-word-fall-through reads.
- The FSM, timer and counters live in `my_if_pair_packer`.

## Test plan
- Reset: hold `reset_n` low with `valid`=1 → `ready`=0, `tx_en`=0, `fifo_count`=0, `pairs_sent`=0; release → `ready`=1 after one edge.
- Back-to-back 8'h11, 8'h22 with `tx_ready`=1 → `tx_en` high for exactly one cycle, 2 cycles after the first accept, with fields 8'h11/8'h22; `pairs_sent`=1.
- Single byte 8'h5A, TIMEOUT=15 → `pad_flush` pulses and `tx_en` rises 15 cycles after HOLD entry, fields 8'h5A/8'h00; with TIMEOUT=0 the byte is held 1000 cycles with no `tx_en`.
- `tx_ready`=0 while streaming 8'h01..8'h08:
  - `ready` drops after 6 bytes accepted (2 held, 4 in FIFO);
  - raising `tx_ready` yields packets (01,02), (03,04), (05,06), (07,08) in order;
  - `pairs_sent`=4.
- Continuous stream with `tx_ready`=1 → one packet every 2 cycles, `ready` never drops, `fifo_count` ≤1.
- `reset_n` pulsed low during SEND with 3 bytes in FIFO → `tx_en` falls immediately; after release, `fifo_count`=0 and no packet is emitted until new bytes arrive.

Source files
------------

// File: rtl/my_if_pair_pkg.sv
// Shared types and constants for the my_if byte-pair packer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package my_if_pair_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD  = 2'd1,
        SEND  = 2'd2
    } pk_state_t;

    localparam logic [7:0] PAD_DEFAULT = 8'h00;

endpackage

// File: rtl/my_if.sv
// Byte valid/ready channel between my_if producers and their consumer.
// Latency: n/a (wires only).
// Backpressure: consumer drives ready; a byte moves when valid && ready.
interface my_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport AccessIn  (output data, output valid, input ready);
    modport AccessOut (input data, input valid, output ready);
endinterface

// File: rtl/struct_if.sv
// Two-byte packet channel toward the transmit stage.
// Latency: n/a (wires only).
// Backpressure: separate tx_ready from the transmit stage qualifies tx_en.
interface struct_if;
    logic [7:0] packet_field1;
    logic [7:0] packet_field2;
    logic       tx_en;

    modport Access  (output packet_field1, output packet_field2, output tx_en);
    modport Monitor (input packet_field1, input packet_field2, input tx_en);
endinterface

// File: rtl/my_if_byte_fifo.sv
// Synchronous first-word-fall-through FIFO; DEPTH must be a power of two.
// Latency: written word visible on rdata the cycle after push.
// Backpressure: push ignored when full, pop ignored when empty.
module my_if_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 wdata,
    output logic [W-1:0]                 rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];
    assign count   = cnt_q;

    // Storage carries no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/my_if_pair_packer.sv
// Packs a my_if byte stream into two-byte struct_if packets, padding a lone byte after TIMEOUT idle cycles.
// Latency: byte accepted at edge N is held at N+1; with a partner at N+1 the packet is offered from N+2.
// Backpressure: registered in_bus.ready from next FIFO occupancy; packet held in SEND until tx_ready.
module my_if_pair_packer
    import my_if_pair_pkg::*;
#(
    parameter int         DEPTH   = 4,
    parameter int         TIMEOUT = 15,
    parameter logic [7:0] PAD     = PAD_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset_n,
    my_if.AccessOut                      in_bus,
    struct_if.Access                     pk_bus,
    input  logic                         tx_ready,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         pad_flush,
    output logic [15:0]                  pairs_sent
);
    localparam int             CW     = $clog2(DEPTH+1);
    localparam int             TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT+1) : 1;
    localparam logic [TW-1:0]  T_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT-1) : '0;
    localparam logic [TW-1:0]  T_MAX  = '1;

    pk_state_t     state_q, state_d;
    logic [7:0]    f1_q, f1_d;
    logic [7:0]    f2_q, f2_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [15:0]   pairs_q, pairs_d;
    logic          flush_d, flush_q;
    logic          in_rdy_q;

    logic          fifo_push;
    logic          fifo_pop;
    logic [7:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] next_count;

    assign fifo_push  = in_bus.valid && in_rdy_q && !fifo_full;
    assign next_count = fifo_count + CW'(fifo_push) - CW'(fifo_pop);

    my_if_byte_fifo #(
        .DEPTH (DEPTH),
        .W     (8)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wdata   (in_bus.data),
        .rdata   (fifo_rdata),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= EMPTY;
            f1_q     <= 8'h00;
            f2_q     <= 8'h00;
            timer_q  <= '0;
            pairs_q  <= 16'h0000;
            flush_q  <= 1'b0;
            in_rdy_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            f1_q     <= f1_d;
            f2_q     <= f2_d;
            timer_q  <= timer_d;
            pairs_q  <= pairs_d;
            flush_q  <= flush_d;
            // Ready lags a same-cycle pop on a full FIFO by one edge, so overflow cannot occur.
            in_rdy_q <= (next_count < CW'(DEPTH));
        end
    end

    always_comb begin
        state_d  = state_q;
        f1_d     = f1_q;
        f2_d     = f2_q;
        timer_d  = timer_q;
        pairs_d  = pairs_q;
        flush_d  = 1'b0;
        fifo_pop = 1'b0;
        case (state_q)
            EMPTY: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    f1_d     = fifo_rdata;
                    timer_d  = '0;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    f2_d     = fifo_rdata;
                    state_d  = SEND;
                end else if (TIMEOUT != 0) begin
                    if (timer_q == T_LAST) begin
                        f2_d    = PAD;
                        flush_d = 1'b1;
                        state_d = SEND;
                    end else if (timer_q != T_MAX) begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            SEND: begin
                if (tx_ready) begin
                    pairs_d = pairs_q + 16'd1;
                    // Refill straight into HOLD to sustain one byte per cycle.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        f1_d     = fifo_rdata;
                        timer_d  = '0;
                        state_d  = HOLD;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    assign in_bus.ready         = in_rdy_q;
    assign pk_bus.packet_field1 = f1_q;
    assign pk_bus.packet_field2 = f2_q;
    assign pk_bus.tx_en         = (state_q == SEND);
    assign pad_flush            = flush_q;
    assign pairs_sent           = pairs_q;

endmodule
